macarray_seq: RTL
=================

// Module: macarray_seq
// PURPOSE
//  Tile sequencer for the 4x4 MAC array. Latches MNT on START, reads weight_transpose/input SRAM rows,
//  loads them into the array, launches and awaits each tile compute, and writes results to OUT_MEM
//  in the 4-column-tile layout (addr = mt*8 + t). Owns all SRAM enables/addresses; datapath holds math only.
// PARAMETERS
//  AW      4   SRAM address width (all three memories)
//  LANE_W  16  result width per output lane; WDATA_O = 4 lanes = 64 bits
// PORTS
//  CLK        in   1   clock
//  RST        in   1   async reset, active-high
//  START      in   1   run request, rising-edge sensitive
//  MNT        in   12  [11:8]=M, [7:4]=N, [3:0]=T, each 1..8
//  BUSY       out  1   high from first LDW cycle until DONE state
//  DONE       out  1   1-cycle pulse at end of run
//  EN_W/ADDR_W out 1/AW  weight SRAM read (data returns next cycle)
//  EN_I/ADDR_I out 1/AW  input SRAM read (data returns next cycle)
//  W_LD_VALID/W_LD_ROW out 1/2  weight row k on RDATA_W this cycle -> array
//  I_LD_VALID/I_LD_ROW out 1/2  input row k on RDATA_I this cycle -> array
//  K_LEN      out  4   latched N, reduction length for datapath
//  CALC_START out  1   1-cycle pulse: compute current tile
//  CALC_DONE  in   1   datapath tile complete (sampled in WAIT)
//  RES_SEL    out  2   result row select; RES_ROW returns combinationally
//  RES_ROW    in   64  datapath result row, lane0 at [63:48]
//  EN_O/RW_O/ADDR_O out 1/1/AW  OUT_MEM port, RW_O=1 write
//  WDATA_O    out  64  masked result row
//  CYC_CNT    out  16  BUSY-cycle count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters 0. Reset mid-run aborts immediately, no further SRAM access.
//  - IDLE: start on START & ~start_q; latch M,N,T; mt=tt=0. START held high never retriggers.
//  - Tile order (mt,tt): (0,0),(0,1),(1,0),(1,1); all 4 tiles always visited -> addr 0..15 all written.
//  - Tile active iff mt*4<M and tt*4<T; inactive tile jumps straight to WR with WDATA_O=0.
//  - LDW (4 cyc, k=0..3): EN_W=1, ADDR_W=mt*4+k only if mt*4+k<M, else EN_W=0. Next cycle
//    W_LD_VALID=1, W_LD_ROW=k for issued reads only.
//  - LDI (4 cyc): same with EN_I, ADDR_I=tt*4+k, bound T, I_LD_VALID/I_LD_ROW.
//  - DRAIN (1 cyc): last I_LD_VALID. CALC (1 cyc): CALC_START=1.
//  - WAIT: hold until CALC_DONE=1 sampled; no timeout.
//  - WR (4 cyc, r=0..3): EN_O=1, RW_O=1, ADDR_O=mt*8+tt*4+r, RES_SEL=r.
//    Lane c (bits [63-16c -: 16]) = RES_ROW lane if tt*4+r<T and mt*4+c<M, else 0.
//  - NEXT (1 cyc): advance tile; after (1,1) go DONE. DONE (1 cyc): DONE=1, BUSY=0, -> IDLE.
//  - Active tile = 15 + wait cycles; inactive tile = 5 cycles (WR+NEXT).
//  - EN_W/EN_I/EN_O never high together with RST; EN_O low outside WR.
//  - K_LEN, masks stable from START latch to DONE; MNT changes mid-run ignored.
// CONFIGURATION
//  MACSEQ_PERF_EN defined: CYC_CNT cleared on start, +1 each BUSY cycle, saturates at 16'hFFFF,
//  holds after DONE until next start. Undefined: CYC_CNT tied 0, no counter flops.
// TESTING (datapath stub: CALC_DONE 5 cyc after CALC_START, RES_ROW = {4{14'h0,RES_SEL}}+lane idx)
//  1. MNT=12'h444 -> W addr 0-3, I addr 0-3, one CALC_START, K_LEN=4; OUT addr 0-3 stub data, 4-15 zero; one DONE.
//  2. MNT=12'h888 -> 4 CALC_STARTs; W addr 4-7 in mt=1 tiles, I addr 4-7 in tt=1; 16 writes, none zero-masked.
//  3. MNT=12'h537 -> mt=1 tiles read only W addr 4 (EN_W=0 for 5-7); lanes1-3 of addr 8-15 zero;
//     addr 7,15 zero; K_LEN=3.
//  4. RST pulse during WAIT of test 1 -> outputs 0 next edge, IDLE; fresh START edge completes normally.
//  5. START held high through DONE -> no second run; drop and re-raise -> second run identical to first.
//  6. MACSEQ_PERF_EN, MNT=12'h444 -> CYC_CNT=35 (20 active + 3x5 inactive); undefined -> CYC_CNT=0.

Source files
------------

// File: rtl/macarray_seq_if.sv
// Sequencer <-> datapath / SRAM / host bundle for the 4x4 MAC array.
// master = sequencer side, slave = datapath, memories and host.
interface macarray_seq_if #(
    parameter int AW     = 4,
    parameter int LANE_W = 16
);
    logic                START;
    logic [11:0]         MNT;
    logic                BUSY;
    logic                DONE;
    logic                EN_W;
    logic [AW-1:0]       ADDR_W;
    logic                EN_I;
    logic [AW-1:0]       ADDR_I;
    logic                W_LD_VALID;
    logic [1:0]          W_LD_ROW;
    logic                I_LD_VALID;
    logic [1:0]          I_LD_ROW;
    logic [3:0]          K_LEN;
    logic                CALC_START;
    logic                CALC_DONE;
    logic [1:0]          RES_SEL;
    logic [4*LANE_W-1:0] RES_ROW;
    logic                EN_O;
    logic                RW_O;
    logic [AW-1:0]       ADDR_O;
    logic [4*LANE_W-1:0] WDATA_O;
    logic [15:0]         CYC_CNT;

    modport master (
        input  START, MNT, CALC_DONE, RES_ROW,
        output BUSY, DONE, EN_W, ADDR_W, EN_I, ADDR_I,
        output W_LD_VALID, W_LD_ROW, I_LD_VALID, I_LD_ROW,
        output K_LEN, CALC_START, RES_SEL,
        output EN_O, RW_O, ADDR_O, WDATA_O, CYC_CNT
    );

    modport slave (
        output START, MNT, CALC_DONE, RES_ROW,
        input  BUSY, DONE, EN_W, ADDR_W, EN_I, ADDR_I,
        input  W_LD_VALID, W_LD_ROW, I_LD_VALID, I_LD_ROW,
        input  K_LEN, CALC_START, RES_SEL,
        input  EN_O, RW_O, ADDR_O, WDATA_O, CYC_CNT
    );
endinterface

// File: rtl/macarray_seq.sv
// Tile sequencer for the 4x4 MAC array: loads, computes, writes 4 tiles.
// Optional busy-cycle counter enabled by defining MACSEQ_PERF_EN.
module macarray_seq #(
    parameter int AW     = 4,
    parameter int LANE_W = 16
) (
    input logic           CLK,
    input logic           RST,
    macarray_seq_if.master bus
);
    localparam int RW = 4 * LANE_W;

    typedef enum logic [3:0] {
        S_IDLE, S_LDW, S_LDI, S_DRAIN, S_CALC,
        S_WAIT, S_WR, S_NEXT, S_DONE
    } state_t;

    state_t     state, state_nxt;
    logic       start_q;
    logic [3:0] m_q, n_q, t_q;
    logic       mt, tt;
    logic [1:0] k;
    logic       w_vld_q, i_vld_q;
    logic [1:0] w_row_q, i_row_q;
    logic       start_re, busy, w_ok, i_ok, nxt_act;
    logic [1:0] tile_nxt;

    assign start_re = bus.START & ~start_q;
    assign busy     = (state != S_IDLE) && (state != S_DONE);
    assign w_ok     = {1'b0, mt, k} < m_q;
    assign i_ok     = {1'b0, tt, k} < t_q;
    assign tile_nxt = {mt, tt} + 2'd1;
    assign nxt_act  = ({1'b0, tile_nxt[1], 2'b00} < m_q) &&
                      ({1'b0, tile_nxt[0], 2'b00} < t_q);

    assign bus.BUSY       = busy;
    assign bus.K_LEN      = n_q;
    assign bus.W_LD_VALID = w_vld_q;
    assign bus.W_LD_ROW   = w_row_q;
    assign bus.I_LD_VALID = i_vld_q;
    assign bus.I_LD_ROW   = i_row_q;

    // state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // next state and per-state outputs
    always_comb begin
        state_nxt      = state;
        bus.DONE       = 1'b0;
        bus.EN_W       = 1'b0;
        bus.ADDR_W     = '0;
        bus.EN_I       = 1'b0;
        bus.ADDR_I     = '0;
        bus.CALC_START = 1'b0;
        bus.RES_SEL    = 2'd0;
        bus.EN_O       = 1'b0;
        bus.RW_O       = 1'b0;
        bus.ADDR_O     = '0;
        bus.WDATA_O    = '0;
        unique case (state)
            S_IDLE: if (start_re) state_nxt = S_LDW;
            S_LDW: begin
                bus.EN_W   = w_ok;
                bus.ADDR_W = AW'({mt, k});
                if (k == 2'd3) state_nxt = S_LDI;
            end
            S_LDI: begin
                bus.EN_I   = i_ok;
                bus.ADDR_I = AW'({tt, k});
                if (k == 2'd3) state_nxt = S_DRAIN;
            end
            S_DRAIN: state_nxt = S_CALC;
            S_CALC: begin
                bus.CALC_START = 1'b1;
                state_nxt      = S_WAIT;
            end
            S_WAIT: if (bus.CALC_DONE) state_nxt = S_WR;
            S_WR: begin
                bus.EN_O    = 1'b1;
                bus.RW_O    = 1'b1;
                bus.ADDR_O  = AW'({mt, tt, k});
                bus.RES_SEL = k;
                for (int c = 0; c < 4; c++) begin
                    if (i_ok && ({1'b0, mt, c[1:0]} < m_q))
                        bus.WDATA_O[RW-1-LANE_W*c -: LANE_W] =
                            bus.RES_ROW[RW-1-LANE_W*c -: LANE_W];
                end
                if (k == 2'd3) state_nxt = S_NEXT;
            end
            S_NEXT: begin
                if ({mt, tt} == 2'b11) state_nxt = S_DONE;
                else if (nxt_act)      state_nxt = S_LDW;
                else                   state_nxt = S_WR;
            end
            S_DONE: begin
                bus.DONE  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // run parameters, tile position and row counter
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            start_q <= 1'b0;
            m_q     <= 4'd0;
            n_q     <= 4'd0;
            t_q     <= 4'd0;
            mt      <= 1'b0;
            tt      <= 1'b0;
            k       <= 2'd0;
        end else begin
            start_q <= bus.START;
            if (state == S_IDLE && start_re) begin
                m_q <= bus.MNT[11:8];
                n_q <= bus.MNT[7:4];
                t_q <= bus.MNT[3:0];
                mt  <= 1'b0;
                tt  <= 1'b0;
                k   <= 2'd0;
            end
            if (state inside {S_LDW, S_LDI, S_WR}) k <= k + 2'd1;
            if (state == S_NEXT) {mt, tt} <= tile_nxt;
        end
    end

    // load strobes follow the SRAM read by one cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            w_vld_q <= 1'b0;
            w_row_q <= 2'd0;
            i_vld_q <= 1'b0;
            i_row_q <= 2'd0;
        end else begin
            w_vld_q <= (state == S_LDW) && w_ok;
            w_row_q <= ((state == S_LDW) && w_ok) ? k : 2'd0;
            i_vld_q <= (state == S_LDI) && i_ok;
            i_row_q <= ((state == S_LDI) && i_ok) ? k : 2'd0;
        end
    end

`ifdef MACSEQ_PERF_EN
    logic [15:0] cyc_q;

    // busy-cycle counter, saturating, held between runs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                            cyc_q <= 16'd0;
        else if (state == S_IDLE && start_re) cyc_q <= 16'd0;
        else if (busy && cyc_q != 16'hFFFF) cyc_q <= cyc_q + 16'd1;
    end

    assign bus.CYC_CNT = cyc_q;
`else
    assign bus.CYC_CNT = 16'd0;
`endif
endmodule
